// File: rtl/mem_access_unit_pkg.sv
// Shared state encoding and default parameters for the memory access unit.
package mem_access_pkg;

    localparam int DEF_ADDR_W      = 18;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_MEM_DEPTH   = 256;
    localparam int DEF_WAIT_CYCLES = 1;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU request/response channel plus the memory-side bus of the access unit.
interface mem_access_unit_if
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_byte;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_read;
    logic              mem_write;
    logic              mem_byte_operations;
    logic [DATA_W-1:0] mem_read_data;

    // The unit itself is the slave; the CPU and memory model together form the master.
    modport slave (
        input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_address, mem_write_data, mem_read, mem_write, mem_byte_operations
    );

    modport master (
        output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
        output resp_ready, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_address, mem_write_data, mem_read, mem_write, mem_byte_operations
    );

endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// Combinational load result shaping: full word, or low byte zero/sign extended.
module load_formatter #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data,
    input  logic              is_byte,
    input  logic              is_signed,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        if (is_byte) begin
            result = {{(DATA_W-8){is_signed & data[7]}}, data[7:0]};
        end else begin
            result = data;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding CPU-to-memory access unit: setup cycle, timed strobe, held response.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input logic              clk,
    input logic              rst_n,
    mem_access_unit_if.slave bus
);

    localparam logic [ADDR_W:0]  DEPTH    = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              is_write;
    logic              is_byte;
    logic              is_signed;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              mem_read;
    logic              mem_write;
    logic              resp_valid;
    logic              resp_err;
    logic [DATA_W-1:0] resp_rdata;
    logic [DATA_W-1:0] load_result;
    logic              out_of_range;

    assign out_of_range = ({1'b0, bus.req_addr} >= DEPTH);

    load_formatter #(.DATA_W(DATA_W)) u_load_formatter (
        .data      (bus.mem_read_data),
        .is_byte   (is_byte),
        .is_signed (is_signed),
        .result    (load_result)
    );

    // resp_valid rises one cycle after entering RESP, so errors answer one cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            is_write   <= 1'b0;
            is_byte    <= 1'b0;
            is_signed  <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        is_write  <= bus.req_write;
                        is_byte   <= bus.req_byte;
                        is_signed <= bus.req_signed;
                        addr      <= bus.req_addr;
                        wdata     <= bus.req_wdata;
                        if (out_of_range) begin
                            state      <= RESP;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    state     <= STROBE;
                    cnt       <= LAST_CNT;
                    mem_read  <= !is_write;
                    mem_write <= is_write;
                end
                STROBE: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        resp_rdata <= is_write ? '0 : load_result;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                    end else if (bus.resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready           = (state == IDLE);
    assign bus.resp_valid          = resp_valid;
    assign bus.resp_err            = resp_err;
    assign bus.resp_rdata          = resp_rdata;
    assign bus.mem_address         = addr;
    assign bus.mem_write_data      = wdata;
    assign bus.mem_byte_operations = is_byte;
    assign bus.mem_read            = mem_read;
    assign bus.mem_write           = mem_write;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed corner cases then randomized traffic against a word-array model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    localparam int AW    = 18;
    localparam int DW    = 32;
    localparam int DEPTH = 256;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
        time           acc_time;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus  ();
    mem_access_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    exp_t          exp_q[$];
    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    int            checks = 0;
    int            passes = 0;
    int            ready_mode = 1;
    int            rd_cycles = 0, wr_cycles = 0, byte_cnt = 0;
    int            overlap_cnt = 0, unexpected_cnt = 0;
    logic [AW-1:0] last_waddr = '0;
    logic [DW-1:0] last_wdata = '0;
    logic          seen_valid = 1'b0;
    logic [DW-1:0] held_rdata = '0;
    logic          held_err = 1'b0;

    assign bus.mem_read_data  = ram[bus.mem_address[7:0]];
    assign bus3.mem_read_data = 32'h1234_5678;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    // Memory behind the bus; it reloads from the reference contents while reset is held.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ram[i] = ref_mem[i];
        end else if (bus.mem_write) begin
            if (bus.mem_byte_operations) ram[bus.mem_address[7:0]][7:0] = bus.mem_write_data[7:0];
            else ram[bus.mem_address[7:0]] = bus.mem_write_data;
        end
    end

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       bus.resp_ready = ($urandom_range(0, 1) == 1);
            1:       bus.resp_ready = 1'b1;
            default: bus.resp_ready = 1'b0;
        endcase
    end

    // Monitor: bus activity counters, response latency, hold-stability and data scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen_valid = 1'b0;
        end else begin
            if (bus.mem_read && bus.mem_write) overlap_cnt++;
            if (bus.mem_read) rd_cycles++;
            if (bus.mem_write) begin
                wr_cycles++;
                last_waddr = bus.mem_address;
                last_wdata = bus.mem_write_data;
            end
            if ((bus.mem_read || bus.mem_write) && bus.mem_byte_operations) byte_cnt++;
            if (bus.resp_valid) begin
                if (exp_q.size() == 0) begin
                    unexpected_cnt++;
                end else begin
                    if (!seen_valid) begin
                        checkOutput("latency", 64'(($time - exp_q[0].acc_time - 5) / 10), 64'(exp_q[0].lat));
                        seen_valid = 1'b1;
                        held_rdata = bus.resp_rdata;
                        held_err   = bus.resp_err;
                    end else begin
                        checkOutput("hold_rdata", 64'(bus.resp_rdata), 64'(held_rdata));
                        checkOutput("hold_err", 64'(bus.resp_err), 64'(held_err));
                    end
                    if (bus.resp_ready) begin
                        checkOutput("resp_rdata", 64'(bus.resp_rdata), 64'(exp_q[0].rdata));
                        checkOutput("resp_err", 64'(bus.resp_err), 64'(exp_q[0].err));
                        void'(exp_q.pop_front());
                        seen_valid = 1'b0;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic byt, input logic sgn,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        exp_t          e;
        int            guard = 0;
        logic [DW-1:0] w;
        @(negedge clk);
        while (!bus.req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            $display("[TB] FAIL accept_timeout: req_ready=0 required=1");
            return;
        end
        bus.req_write  = wr;
        bus.req_byte   = byt;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        e.acc_time = $time;
        if (addr >= AW'(DEPTH)) begin
            e.err = 1'b1; e.rdata = '0; e.lat = 1;
        end else begin
            e.err = 1'b0; e.lat = 3;
            if (wr) begin
                e.rdata = '0;
                if (byt) ref_mem[addr[7:0]][7:0] = wdata[7:0];
                else ref_mem[addr[7:0]] = wdata;
            end else begin
                w = ref_mem[addr[7:0]];
                if (!byt) e.rdata = w;
                else if (sgn) e.rdata = DW'(int'($signed(w[7:0])));
                else e.rdata = DW'(w[7:0]);
            end
        end
        exp_q.push_back(e);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_write  = ($urandom_range(0, 1) == 1);
        bus.req_byte   = ($urandom_range(0, 1) == 1);
        bus.req_signed = ($urandom_range(0, 1) == 1);
        bus.req_addr   = AW'($urandom);
        bus.req_wdata  = $urandom;
    endtask

    task automatic waitIdle();
        int guard = 0;
        while ((exp_q.size() != 0 || !bus.req_ready) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            checks++;
            $display("[TB] FAIL idle_timeout: pending=%0d required=0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int            w0, r0, b0, u0, guard, cnt3, lat3;
        time           t0;
        logic [DW-1:0] hold;
        logic [AW-1:0] a;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
        ref_mem[10] = 32'h0000_00F0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_byte = 1'b0; bus.req_signed = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0;
        bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_byte = 1'b0; bus3.req_signed = 1'b0;
        bus3.req_addr = '0; bus3.req_wdata = '0; bus3.resp_ready = 1'b1;

        @(negedge clk);
        checkOutput("rst_resp_valid", 64'(bus.resp_valid), 0);
        checkOutput("rst_resp_err", 64'(bus.resp_err), 0);
        checkOutput("rst_resp_rdata", 64'(bus.resp_rdata), 0);
        checkOutput("rst_req_ready", 64'(bus.req_ready), 1);
        checkOutput("rst_mem_strobes", 64'({bus.mem_read, bus.mem_write, bus.mem_byte_operations}), 0);
        checkOutput("rst_mem_address", 64'(bus.mem_address), 0);
        checkOutput("rst_mem_wdata", 64'(bus.mem_write_data), 0);

        // A request presented while reset is low must be ignored.
        bus.req_valid = 1'b1; bus.req_addr = AW'(300);
        @(posedge clk); @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("no_accept_in_reset", 64'(bus.resp_valid), 0);
        checkOutput("ready_after_reset", 64'(bus.req_ready), 1);

        w0 = wr_cycles;
        applyStimulus(1'b1, 1'b0, 1'b0, AW'(5), 32'hDEAD_BEEF);
        waitIdle();
        checkOutput("store_strobe_cycles", 64'(wr_cycles - w0), 1);
        checkOutput("store_address", 64'(last_waddr), 5);
        checkOutput("store_wdata", 64'(last_wdata), 64'h0000_0000_DEAD_BEEF);

        b0 = byte_cnt;
        applyStimulus(1'b0, 1'b1, 1'b1, AW'(10), '0);
        waitIdle();
        applyStimulus(1'b0, 1'b1, 1'b0, AW'(10), '0);
        waitIdle();
        checkOutput("byte_strobe_cycles", 64'(byte_cnt - b0), 2);

        r0 = rd_cycles; w0 = wr_cycles;
        applyStimulus(1'b0, 1'b0, 1'b0, AW'(300), '0);
        waitIdle();
        checkOutput("oor_no_strobe", 64'((rd_cycles - r0) + (wr_cycles - w0)), 0);

        ready_mode = 2;
        applyStimulus(1'b0, 1'b0, 1'b0, AW'(20), '0);
        guard = 0;
        while (!bus.resp_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("bp_resp_seen", 64'(bus.resp_valid), 1);
        hold = bus.resp_rdata;
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_valid", 64'(bus.resp_valid), 1);
            checkOutput("bp_rdata", 64'(bus.resp_rdata), 64'(hold));
            checkOutput("bp_req_ready", 64'(bus.req_ready), 0);
        end
        ready_mode = 1;
        waitIdle();

        applyStimulus(1'b1, 1'b0, 1'b0, AW'(7), ref_mem[7]);
        guard = 0;
        while (!bus.mem_write && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("rst_strobe_seen", 64'(bus.mem_write), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_drops_write", 64'(bus.mem_write), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        u0 = unexpected_cnt;
        repeat (10) @(negedge clk);
        checkOutput("rst_no_resp", 64'(unexpected_cnt - u0), 0);
        checkOutput("rst_req_ready", 64'(bus.req_ready), 1);

        @(negedge clk);
        checkOutput("w3_ready", 64'(bus3.req_ready), 1);
        bus3.req_addr = AW'(2);
        bus3.req_valid = 1'b1;
        @(posedge clk);
        t0 = $time;
        #1;
        bus3.req_valid = 1'b0;
        cnt3 = 0; lat3 = -1;
        for (int k = 0; k < 20 && lat3 < 0; k++) begin
            @(negedge clk);
            if (bus3.mem_read) cnt3++;
            if (bus3.resp_valid) lat3 = int'(($time - t0 - 5) / 10);
        end
        checkOutput("w3_latency", 64'(lat3), 5);
        checkOutput("w3_read_cycles", 64'(cnt3), 3);
        checkOutput("w3_rdata", 64'(bus3.resp_rdata), 64'h0000_0000_1234_5678);

        ready_mode = 0;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) a = AW'($urandom_range(256, 400));
            else a = AW'($urandom_range(0, 31));
            applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1, a, $urandom);
        end
        ready_mode = 1;
        waitIdle();

        checkOutput("no_strobe_overlap", 64'(overlap_cnt), 0);
        checkOutput("no_unexpected_resp", 64'(unexpected_cnt), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
